// File: rtl/clk_rst_pkg.sv
// Shared types and helpers for the clock/reset sequencer.
package clk_rst_pkg;

    typedef enum logic [2:0] {
        RESET_DCM = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_e;

    localparam int RETRY_W = 3;

    // Width of the shared counter: enough bits to reach the largest window length.
    function automatic int cntWidth(int a, int b, int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/clk_rst_sequencer_bit_sync.sv
// Two-flop synchronizer for a single asynchronous level, async reset to 0.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_rst_sequencer.sv
// Power-up clock/reset sequencer: pulses the DCM reset, waits for lock with bounded
// retries, and holds sysRst until lock has stayed up for a full settle window.
module clk_rst_sequencer
    import clk_rst_pkg::*;
#(
    parameter int DCM_RST_CYCLES = 4,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 7,
    parameter int LOSS_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkLocked,
    output logic              dcmRst,
    output logic              sysRst,
    output logic              ready,
    output logic              lockFail,
    output logic [2:0]        retryCount,
    output logic [LOSS_W-1:0] lossCount
);
    localparam int CW = cntWidth(DCM_RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
    localparam logic [CW-1:0] DcmLast     = CW'(DCM_RST_CYCLES - 1);
    localparam logic [CW-1:0] TimeoutLast = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] SettleLast  = CW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    RetryMax    = 3'(MAX_RETRIES);

    state_e        state;
    logic [CW-1:0] cnt;
    logic          lockS;

    bit_sync syncLock (
        .clk (clk),
        .rst (rst),
        .d   (clkLocked),
        .q   (lockS)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RESET_DCM;
            cnt        <= '0;
            dcmRst     <= 1'b1;
            sysRst     <= 1'b1;
            ready      <= 1'b0;
            lockFail   <= 1'b0;
            retryCount <= '0;
            lossCount  <= '0;
        end else begin
            unique case (state)
                RESET_DCM: begin
                    if (cnt == DcmLast) begin
                        state  <= WAIT_LOCK;
                        cnt    <= '0;
                        dcmRst <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    // Lock takes priority over a coincident timeout.
                    if (lockS) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end else if (cnt == TimeoutLast) begin
                        cnt    <= '0;
                        dcmRst <= 1'b1;
                        if (retryCount == RetryMax) begin
                            state    <= FAIL;
                            lockFail <= 1'b1;
                        end else begin
                            state      <= RESET_DCM;
                            retryCount <= retryCount + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    if (!lockS) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == SettleLast) begin
                        state      <= RUN;
                        cnt        <= '0;
                        sysRst     <= 1'b0;
                        ready      <= 1'b1;
                        retryCount <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!lockS) begin
                        state  <= RESET_DCM;
                        cnt    <= '0;
                        dcmRst <= 1'b1;
                        sysRst <= 1'b1;
                        ready  <= 1'b0;
                        if (lossCount != '1) lossCount <= lossCount + 1'b1;
                    end
                end
                FAIL: begin
                    dcmRst   <= 1'b1;
                    sysRst   <= 1'b1;
                    ready    <= 1'b0;
                    lockFail <= 1'b1;
                end
                default: begin
                    state  <= RESET_DCM;
                    cnt    <= '0;
                    dcmRst <= 1'b1;
                    sysRst <= 1'b1;
                    ready  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Scoreboard bench for clk_rst_sequencer: an interval-based model predicts every output
// change for a given clkLocked waveform; a monitor checks each change the DUT presents.
module tb_clk_rst_sequencer;

    localparam int DCM  = 4;
    localparam int TO   = 16;
    localparam int SET  = 8;
    localparam int MAXR = 2;
    localparam int MAXN = 9100;

    localparam logic [14:0] RST_V = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clkLocked = 1'b0;
    logic       dcmRst, sysRst, ready, lockFail;
    logic [2:0] retryCount;
    logic [7:0] lossCount;

    clk_rst_sequencer #(
        .DCM_RST_CYCLES (DCM),
        .LOCK_TIMEOUT   (TO),
        .SETTLE_CYCLES  (SET),
        .MAX_RETRIES    (MAXR),
        .LOSS_W         (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .clkLocked  (clkLocked),
        .dcmRst     (dcmRst),
        .sysRst     (sysRst),
        .ready      (ready),
        .lockFail   (lockFail),
        .retryCount (retryCount),
        .lossCount  (lossCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          edgeNo;
        logic [14:0] v;
    } ev_t;

    ev_t         sb[$];
    bit          lvl[0:MAXN];
    logic [14:0] expO[0:MAXN];
    int          tests = 0;
    int          failed = 0;
    int          edgeNo = 0;
    bit          monOn = 1'b0;
    logic [14:0] prevV = RST_V;

    function automatic logic [14:0] outVec();
        return {dcmRst, sysRst, ready, lockFail, retryCount, lossCount};
    endfunction

    function automatic logic [14:0] pack(bit d, bit s, bit r, bit f, int rc, int lc);
        return {d, s, r, f, 3'(rc), 8'(lc)};
    endfunction

    // lockS as seen by the FSM at edge k: clkLocked sampled two edges earlier.
    function automatic bit sAt(int k);
        return (k > 2) ? lvl[k-2] : 1'b0;
    endfunction

    task automatic fillFrom(input int from, input int n, input logic [14:0] v);
        for (int k = from; k <= n; k++) expO[k] = v;
    endtask

    task automatic setRange(input int a, input int b, input bit v);
        for (int k = a; k <= b; k++) lvl[k] = v;
    endtask

    // Walks the attempt / wait / settle / run intervals and records the output vector
    // expected after every edge 0..n.
    task automatic buildModel(input int n);
        int  pos, w, e, x, retry, loss, ph;
        bit  done, found;
        fillFrom(0, n, RST_V);
        retry = 0; loss = 0; pos = 0; ph = 0; done = 1'b0; w = 0; e = 0;
        while (!done) begin
            if (ph == 0) begin
                w = pos + DCM;
                if (w > n) done = 1'b1;
                else begin
                    fillFrom(w, n, pack(0, 1, 0, 0, retry, loss));
                    ph = 1;
                end
            end else if (ph == 1) begin
                found = 1'b0;
                e = w + 1;
                while (e <= w + TO && e <= n && !found) begin
                    if (sAt(e)) found = 1'b1;
                    else e++;
                end
                if (found) ph = 2;
                else if (e > w + TO) begin
                    e = w + TO;
                    if (retry == MAXR) begin
                        fillFrom(e, n, pack(1, 1, 0, 1, retry, loss));
                        done = 1'b1;
                    end else begin
                        retry++;
                        fillFrom(e, n, pack(1, 1, 0, 0, retry, loss));
                        pos = e;
                        ph = 0;
                    end
                end else done = 1'b1;
            end else if (ph == 2) begin
                x = e + 1;
                while (x <= e + SET && x <= n && sAt(x)) x++;
                if (x > e + SET) begin
                    retry = 0;
                    pos = e + SET;
                    fillFrom(pos, n, pack(0, 0, 1, 0, 0, loss));
                    ph = 3;
                end else if (x > n) done = 1'b1;
                else begin
                    w = x;
                    ph = 1;
                end
            end else begin
                x = pos + 1;
                while (x <= n && sAt(x)) x++;
                if (x > n) done = 1'b1;
                else begin
                    if (loss < 255) loss++;
                    fillFrom(x, n, pack(1, 1, 0, 0, 0, loss));
                    pos = x;
                    ph = 0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        if (monOn) begin
            logic [14:0] cur;
            ev_t         ev;
            edgeNo++;
            #1;
            cur = outVec();
            if (cur !== prevV) begin
                tests++;
                if (sb.size() == 0) begin
                    failed++;
                    $display("FAIL sb-unexpected edge=%0d got=%h (no change expected)", edgeNo, cur);
                end else begin
                    ev = sb.pop_front();
                    if (ev.edgeNo != edgeNo || ev.v !== cur) begin
                        failed++;
                        $display("FAIL sb-event got edge=%0d val=%h, expected edge=%0d val=%h",
                                 edgeNo, cur, ev.edgeNo, ev.v);
                    end
                end
                prevV = cur;
            end
        end
    end

    // Asynchronous reset check (no clock edge), then drive lvl[1..n] edge by edge.
    task automatic runScenario(input int n);
        logic [14:0] cur;
        @(negedge clk);
        monOn = 1'b0;
        #2 rst = 1'b1;
        clkLocked = 1'b0;
        #1;
        cur = outVec();
        tests++;
        if (cur !== RST_V) begin
            failed++;
            $display("FAIL rst-async got=%h expected=%h", cur, RST_V);
        end
        buildModel(n);
        sb.delete();
        for (int k = 1; k <= n; k++)
            if (expO[k] !== expO[k-1]) sb.push_back('{k, expO[k]});
        @(negedge clk);
        rst = 1'b0;
        edgeNo = 0;
        prevV = RST_V;
        monOn = 1'b1;
        for (int k = 1; k <= n; k++) begin
            clkLocked = lvl[k];
            @(negedge clk);
        end
        monOn = 1'b0;
        tests++;
        if (sb.size() != 0) begin
            failed++;
            $display("FAIL sb-leftover got=%0d pending events, expected=0 (next edge=%0d)",
                     sb.size(), sb[0].edgeNo);
        end
        sb.delete();
    endtask

    initial begin
        int n, k, len, maxLen;
        bit v;

        // Lock 5 cycles after dcmRst falls.
        setRange(0, 40, 1'b0); setRange(9, 40, 1'b1);
        runScenario(40);

        // Never locks: three attempts, then sticky failure.
        setRange(0, 90, 1'b0);
        runScenario(90);

        // Lock drops at settle count 5, then returns.
        setRange(0, 60, 1'b0); setRange(9, 60, 1'b1); lvl[15] = 1'b0;
        runScenario(60);

        // Stop while in SETTLE; the next reset lands mid-settle.
        setRange(0, 14, 1'b0); setRange(9, 14, 1'b1);
        runScenario(14);

        // lockS rises exactly on the first timeout cycle.
        setRange(0, 50, 1'b0); setRange(18, 50, 1'b1);
        runScenario(50);

        // lockS rises exactly on the second attempt's timeout cycle.
        setRange(0, 70, 1'b0); setRange(38, 70, 1'b1);
        runScenario(70);

        // 300 single-cycle lock losses while running.
        n = 9030;
        setRange(0, n, 1'b0); setRange(5, n, 1'b1);
        for (int m = 1; m <= 300; m++) lvl[30 * m] = 1'b0;
        runScenario(n);
        tests++;
        if (lossCount !== 8'hFF) begin
            failed++;
            $display("FAIL loss-saturate got=%0d expected=255", lossCount);
        end

        // Random lock waveforms.
        for (int s = 0; s < 10; s++) begin
            n = 300;
            maxLen = (s % 2 == 1) ? 40 : 12;
            lvl[0] = 1'b0;
            k = 1;
            while (k <= n) begin
                len = $urandom_range(maxLen, 1);
                v = ($urandom_range(3, 0) != 0);
                for (int j = 0; j < len && k <= n; j++) begin
                    lvl[k] = v;
                    k++;
                end
            end
            runScenario(n);
        end

        // Final reset taken from wherever the last waveform left the block.
        setRange(0, 30, 1'b0);
        runScenario(30);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
